// File: rtl/parity_bit_gen_pkg.sv
// Shared definitions for the parity bit generator slice: parity mode
// encodings and the saturation limit helper for the error counter.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  // All-ones value of a w-bit counter, w in 1..16; w=16 wraps the shift to 0 so -1 gives 16'hFFFF.
  function automatic logic [15:0] cnt_max(input int unsigned w);
    return (16'd1 << w) - 16'd1;
  endfunction

endpackage

// File: rtl/parity_bit_gen_if.sv
// Nibble/parity bus between a source and the parity generator/checker.
interface parity_bit_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             odd_sel;
  logic             chk_en;
  logic             par_in;
  logic             E;
  logic [3:0]       data_out;
  logic             out_valid;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, A, B, C, D, odd_sel, chk_en, par_in,
    input  E, data_out, out_valid, err, err_cnt
  );

  modport slave (
    input  in_valid, A, B, C, D, odd_sel, chk_en, par_in,
    output E, data_out, out_valid, err, err_cnt
  );
endinterface

// File: rtl/parity_bit_gen_tree.sv
// Combinational XOR tree: parity of a nibble, inverted in odd mode.
module parity_tree
  import parity_pkg::*;
(
  input  logic [3:0] data,
  input  par_mode_e  mode,
  output logic       par
);
  always_comb begin
    par = ^data ^ 1'(mode);
  end
endmodule

// File: rtl/parity_bit_gen.sv
// Registered 4-bit parity generator/checker, one-cycle latency, with a
// saturating mismatch counter. Every output comes straight from a flop.
module parity_bit_gen
  import parity_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter bit          RESET_ODD = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  parity_bit_gen_if.slave  bus
);

  localparam logic [15:0]      CNT_MAX_W = cnt_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];

  logic [3:0]       nib;
  logic             p;
  par_mode_e        mode;
  logic             e_q;
  logic [3:0]       data_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  assign nib = {bus.A, bus.B, bus.C, bus.D};

  parity_tree u_tree (
    .data (nib),
    .mode (mode),
    .par  (p)
  );

  // Mode is the value registered before this edge, so odd_sel lags one sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode    <= par_mode_e'(RESET_ODD);
      e_q     <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mode    <= par_mode_e'(bus.odd_sel);
      valid_q <= bus.in_valid;
      err_q   <= 1'b0;
      if (bus.in_valid) begin
        e_q    <= p;
        data_q <= nib;
        if (bus.chk_en && (bus.par_in != p)) begin
          err_q <= 1'b1;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.E         = e_q;
  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_parity_bit_gen.sv
// Directed bench for parity_bit_gen: main instance (CNT_W=8, even reset mode)
// and a narrow instance (CNT_W=2, odd reset mode) for saturation.
module tb_parity_bit_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  parity_bit_gen_if #(.CNT_W(8)) bus  ();
  parity_bit_gen_if #(.CNT_W(2)) bus2 ();

  parity_bit_gen #(.CNT_W(8), .RESET_ODD(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  parity_bit_gen #(.CNT_W(2), .RESET_ODD(1'b1)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  task automatic drive(input logic v, input logic [3:0] n, input logic os,
                       input logic ce, input logic pi);
    bus.in_valid = v;
    {bus.A, bus.B, bus.C, bus.D} = n;
    bus.odd_sel = os;
    bus.chk_en  = ce;
    bus.par_in  = pi;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.E !== 1'b0 || bus.data_out !== 4'h0 || bus.out_valid !== 1'b0 ||
        bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: E=%b data_out=%h out_valid=%b err=%b err_cnt=%0d, need all 0",
               bus.E, bus.data_out, bus.out_valid, bus.err, bus.err_cnt);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_even_sweep;
    logic [3:0] nv;
    logic       exp_e;
    for (int i = 0; i < 16; i++) begin
      nv = 4'(i);
      exp_e = nv[3] ^ nv[2] ^ nv[1] ^ nv[0];
      drive(1'b1, nv, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.E !== exp_e || bus.data_out !== nv || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL even_sweep %b: E=%b data_out=%b out_valid=%b, need E=%b data_out=%b out_valid=1",
                 nv, bus.E, bus.data_out, bus.out_valid, exp_e, nv);
      end
    end
  endtask

  task automatic test_odd_mode;
    logic [3:0] nv  [5] = '{4'b0000, 4'b0111, 4'b1111, 4'b0000, 4'b0000};
    logic       os  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    // Sample 3 requests even mode but still sees odd; sample 4 sees even.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, nv[i], os[i], 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.E !== exp[i] || bus.data_out !== nv[i]) begin
        errors++;
        $display("FAIL odd_mode[%0d] %b: E=%b data_out=%b, need E=%b data_out=%b",
                 i, nv[i], bus.E, bus.data_out, exp[i], nv[i]);
      end
    end
  endtask

  task automatic test_checker;
    drive(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0 || bus.E !== 1'b0) begin
      errors++;
      $display("FAIL chk_match: err=%b err_cnt=%0d E=%b, need err=0 err_cnt=0 E=0",
               bus.err, bus.err_cnt, bus.E);
    end
    drive(1'b1, 4'b1010, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL chk_mismatch: err=%b err_cnt=%0d, need err=1 err_cnt=1",
               bus.err, bus.err_cnt);
    end
    drive(1'b0, 4'b1010, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.err_cnt !== 8'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL chk_invalid: err=%b err_cnt=%0d out_valid=%b, need err=0 err_cnt=1 out_valid=0",
               bus.err, bus.err_cnt, bus.out_valid);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_e   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       pi;
    rst2_n = 1'b1;
    // First post-reset sample runs in the odd reset mode, so parity of 0000 is 1.
    for (int i = 0; i < 5; i++) begin
      pi = (i == 0) ? 1'b0 : 1'b1;
      bus2.in_valid = 1'b1;
      {bus2.A, bus2.B, bus2.C, bus2.D} = 4'b0000;
      bus2.odd_sel = 1'b0;
      bus2.chk_en  = 1'b1;
      bus2.par_in  = pi;
      tick();
      checks++;
      if (bus2.err !== 1'b1 || bus2.err_cnt !== exp_cnt[i] || bus2.E !== exp_e[i]) begin
        errors++;
        $display("FAIL saturation[%0d]: err=%b err_cnt=%0d E=%b, need err=1 err_cnt=%0d E=%b",
                 i, bus2.err, bus2.err_cnt, bus2.E, exp_cnt[i], exp_e[i]);
      end
    end
    bus2.in_valid = 1'b0;
    tick();
    checks++;
    if (bus2.err !== 1'b0 || bus2.err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturation_hold: err=%b err_cnt=%0d, need err=0 err_cnt=3",
               bus2.err, bus2.err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL pre_reset_cnt: err_cnt=%0d, need 2", bus.err_cnt);
    end
    drive(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.E !== 1'b0 || bus.data_out !== 4'h0 || bus.out_valid !== 1'b0 ||
        bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: E=%b data_out=%h out_valid=%b err=%b err_cnt=%0d, need all 0",
               bus.E, bus.data_out, bus.out_valid, bus.err, bus.err_cnt);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.E !== 1'b1 || bus.data_out !== 4'b0001 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: E=%b data_out=%b out_valid=%b, need E=1 data_out=0001 out_valid=1",
               bus.E, bus.data_out, bus.out_valid);
    end
  endtask

  task automatic test_idle_hold;
    logic [3:0] nv [3] = '{4'b1110, 4'b0011, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, nv[i], 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (bus.E !== 1'b1 || bus.data_out !== 4'b0001 || bus.out_valid !== 1'b0 ||
          bus.err !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: E=%b data_out=%b out_valid=%b err=%b, need E=1 data_out=0001 out_valid=0 err=0",
                 i, bus.E, bus.data_out, bus.out_valid, bus.err);
      end
    end
  endtask

  initial begin
    rst2_n = 1'b0;
    bus2.in_valid = 1'b0;
    {bus2.A, bus2.B, bus2.C, bus2.D} = 4'h0;
    bus2.odd_sel = 1'b0;
    bus2.chk_en  = 1'b0;
    bus2.par_in  = 1'b0;
    test_reset();
    test_even_sweep();
    test_odd_mode();
    test_checker();
    test_saturation();
    test_reset_mid();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
